// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the data memory: funct3 load/store encodings and XLEN.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/data_memory_if.sv
// MEM-stage bus between the pipeline (master) and the data memory (slave).
interface data_memory_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            func3;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output MemRead, MemWrite, func3, addr, data_in,
        input  data_out
    );

    modport slave (
        input  MemRead, MemWrite, func3, addr, data_in,
        output data_out
    );
endinterface

// File: rtl/data_memory_load_extend.sv
// Turns the raw little-endian word at A..A+3 into the sized, sign/zero-extended load result.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] raw_word,
    input  logic [2:0]      func3,
    input  logic            mem_read,
    output logic [XLEN-1:0] data_out
);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s   = raw_word[7:0];
        half_s   = raw_word[15:0];
        data_out = '0;
        if (mem_read) begin
            unique case (func3)
                F3_B:    data_out = XLEN'(byte_s);
                F3_H:    data_out = XLEN'(half_s);
                F3_W:    data_out = raw_word;
                F3_BU:   data_out = {{(XLEN-8){1'b0}}, raw_word[7:0]};
                F3_HU:   data_out = {{(XLEN-16){1'b0}}, raw_word[15:0]};
                default: data_out = '0;
            endcase
        end
    end
endmodule

// File: rtl/data_memory.sv
// Byte-addressable RV32I data memory: synchronous byte-lane stores, combinational extended loads.
module data_memory
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx [4];
    logic [3:0]            we_d;
    logic [7:0]            wdata_d [4];
    logic [DATA_WIDTH-1:0] raw_word;
    logic                  unused_addr_hi;

    assign unused_addr_hi = &{1'b0, bus.addr[31:ADDR_WIDTH]};

    // Lane k always targets byte A+k; the ADDR_WIDTH-bit add wraps the top of memory to 0.
    always_comb begin
        we_d = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx[k]     = bus.addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
            wdata_d[k] = bus.data_in[8*k +: 8];
        end
        if (bus.MemWrite) begin
            unique case (bus.func3)
                F3_B:    we_d = 4'b0001;
                F3_H:    we_d = 4'b0011;
                F3_W:    we_d = 4'b1111;
                default: we_d = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (we_d[k]) begin
                    mem_q[idx[k]] <= wdata_d[k];
                end
            end
        end
    end

    assign raw_word = {mem_q[idx[3]], mem_q[idx[2]], mem_q[idx[1]], mem_q[idx[0]]};

    load_extend u_load_extend (
        .raw_word (raw_word),
        .func3    (bus.func3),
        .mem_read (bus.MemRead),
        .data_out (bus.data_out)
    );
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed load/store cases plus random traffic against a byte-array model.
module tb_data_memory;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] ref_mem [DEPTH];

    data_memory_if #(.DATA_WIDTH(32)) bus ();

    data_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic int wrap(input logic [31:0] a, input int off);
        return (int'(a % DEPTH) + off) % DEPTH;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic rd);
        int b, h;
        longint w;
        if (!rd) return 32'h0;
        b = ref_mem[wrap(a, 0)];
        h = b + 256 * ref_mem[wrap(a, 1)];
        w = longint'(h) + 65536 * ref_mem[wrap(a, 2)] + 16777216 * longint'(ref_mem[wrap(a, 3)]);
        case (f3)
            3'd0: return 32'(b > 127 ? b - 256 : b);
            3'd1: return 32'(h > 32767 ? h - 65536 : h);
            3'd2: return 32'(w);
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        for (int i = 0; i < n; i++) ref_mem[wrap(a, i)] = d[8*i +: 8];
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endfunction

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite = 1'b1;
        bus.MemRead  = 1'b0;
        bus.func3    = f3;
        bus.addr     = a;
        bus.data_in  = d;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        ref_store(f3, a, d);
    endtask

    // Checks against both the literal expectation and the model, then realigns to posedge+1.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic rd, input logic [31:0] exp);
        bus.MemWrite = 1'b0;
        bus.MemRead  = rd;
        bus.func3    = f3;
        bus.addr     = a;
        #2;
        check(tag, bus.data_out, exp);
        check({tag, "_model"}, bus.data_out, ref_load(f3, a, rd));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, d, old_v;
        logic        rd;
        total = 0;
        bad   = 0;
        ref_clear();
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.func3    = 3'd0;
        bus.addr     = 32'h0;
        bus.data_in  = 32'h0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_load("rst_lw0", 3'd2, 32'h0, 1'b1, 32'h0);
        do_load("rst_lw_top", 3'd2, 32'hFFC, 1'b1, 32'h0);

        do_store(3'd2, 32'h0, 32'h000006F4);
        do_load("lb0", 3'd0, 32'h0, 1'b1, 32'hFFFFFFF4);
        do_load("lbu0", 3'd4, 32'h0, 1'b1, 32'h000000F4);

        do_store(3'd2, 32'h4, 32'h0004E634);
        do_load("lh4", 3'd1, 32'h4, 1'b1, 32'hFFFFE634);
        do_load("lhu4", 3'd5, 32'h4, 1'b1, 32'h0000E634);
        do_load("lw4", 3'd2, 32'h4, 1'b1, 32'h0004E634);

        do_store(3'd2, 32'h0, 32'h030106F4);
        do_load("lw0", 3'd2, 32'h0, 1'b1, 32'h030106F4);

        do_store(3'd2, 32'h8, 32'hAABBCCDD);
        do_store(3'd0, 32'h9, 32'h00000011);
        do_store(3'd1, 32'hA, 32'h00002233);
        do_load("partial", 3'd2, 32'h8, 1'b1, 32'h223311DD);

        do_load("rd_off", 3'd2, 32'h8, 1'b0, 32'h0);
        do_load("f3_011", 3'd3, 32'h8, 1'b1, 32'h0);
        do_load("f3_111", 3'd7, 32'h8, 1'b1, 32'h0);
        do_store(3'd7, 32'h8, 32'h12345678);
        do_load("nowrite_111", 3'd2, 32'h8, 1'b1, 32'h223311DD);

        do_store(3'd2, 32'h0, 32'h44332211);
        do_store(3'd2, 32'h4, 32'h88776655);
        do_load("unaligned", 3'd2, 32'h1, 1'b1, 32'h55443322);
        do_load("alias", 3'd2, 32'h0001_2004, 1'b1, 32'h88776655);

        do_store(3'd2, 32'hFFE, 32'hA1B2C3D4);
        do_load("wrap_lw", 3'd2, 32'hFFE, 1'b1, 32'hA1B2C3D4);
        do_load("wrap_lhu1", 3'd5, 32'h0, 1'b1, 32'h0000A1B2);

        // Read during write: old data before the edge, new data after, no bypass.
        bus.MemWrite = 1'b1;
        bus.MemRead  = 1'b1;
        bus.func3    = 3'd2;
        bus.addr     = 32'h4;
        bus.data_in  = 32'hCAFEF00D;
        #2;
        check("rdw_before", bus.data_out, 32'h88776655);
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        ref_store(3'd2, 32'h4, 32'hCAFEF00D);
        check("rdw_after", bus.data_out, 32'hCAFEF00D);

        // Reset wins over a simultaneous store.
        do_store(3'd2, 32'h20, 32'h11112222);
        bus.MemWrite = 1'b1;
        bus.MemRead  = 1'b0;
        bus.func3    = 3'd2;
        bus.addr     = 32'h20;
        bus.data_in  = 32'hDEADBEEF;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.MemWrite = 1'b0;
        ref_clear();
        do_load("rst2_lw0", 3'd2, 32'h0, 1'b1, 32'h0);
        do_load("rst2_lw4", 3'd2, 32'h4, 1'b1, 32'h0);
        do_load("rst2_lw20", 3'd2, 32'h20, 1'b1, 32'h0);
        do_load("rst2_wrap", 3'd2, 32'hFFE, 1'b1, 32'h0);

        for (int it = 0; it < 400; it++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a = (a & 32'hFFFF_F000) |
                    (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(DEPTH - 6, DEPTH - 1)));
            end
            if ($urandom_range(0, 1) == 1) begin
                do_store(f3, a, d);
            end else begin
                rd = ($urandom_range(0, 7) != 0);
                bus.MemWrite = 1'b0;
                bus.MemRead  = rd;
                bus.func3    = f3;
                bus.addr     = a;
                #2;
                old_v = ref_load(f3, a, rd);
                check("rand_load", bus.data_out, old_v);
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
